// File: rtl/evento_pontos.sv
// Scoring-event front end: synchronizes and debounces three active-low point
// buttons, then offers exactly one +1/+2/+3 event per accepted press through a
// valid/ready handshake. Presses of two or more buttons are discarded with a
// one-cycle rejeitado pulse.
module evento_pontos #(
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn,
    input  logic       sinal,
    input  logic       ready,
    output logic       valid,
    output logic [1:0] pontos,
    output logic       sub,
    output logic       rejeitado
);

    localparam logic [15:0] CountLast = 16'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        ISSUE,
        RELEASE
    } state_t;

    logic [2:0]  btnMeta_q;
    logic [2:0]  btnSync_q;
    logic        sinalMeta_q;
    logic        sinalSync_q;
    logic [2:0]  press;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [2:0]  cand_q, cand_d;
    logic        valid_q, valid_d;
    logic [1:0]  pontos_q, pontos_d;
    logic        sub_q, sub_d;
    logic        rej_q, rej_d;
    logic [1:0]  candValue;

    // Point value of a single-button candidate; zero marks a multi-button press.
    function automatic logic [1:0] pointValue(input logic [2:0] v);
        logic [1:0] r;
        case (v)
            3'b001:  r = 2'd1;
            3'b010:  r = 2'd2;
            3'b100:  r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    assign press     = ~btnSync_q;
    assign candValue = pointValue(cand_q);

    // Two-flop synchronizers; buttons come back to the released level on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btnMeta_q   <= 3'b111;
            btnSync_q   <= 3'b111;
            sinalMeta_q <= 1'b1;
            sinalSync_q <= 1'b1;
        end else begin
            btnMeta_q   <= btn;
            btnSync_q   <= btnMeta_q;
            sinalMeta_q <= sinal;
            sinalSync_q <= sinalMeta_q;
        end
    end

    // State, stability counter, candidate and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            cand_q   <= '0;
            valid_q  <= 1'b0;
            pontos_q <= '0;
            sub_q    <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            cand_q   <= cand_d;
            valid_q  <= valid_d;
            pontos_q <= pontos_d;
            sub_q    <= sub_d;
            rej_q    <= rej_d;
        end
    end

    // Debounce, issue and release sequencing; the counter is cleared on every transition.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        cand_d   = cand_q;
        valid_d  = valid_q;
        pontos_d = pontos_q;
        sub_d    = sub_q;
        rej_d    = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (press != 3'b000) begin
                    cand_d  = press;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (press == 3'b000) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (press != cand_q) begin
                    cand_d  = press;
                    count_d = '0;
                end else if (count_q == CountLast) begin
                    count_d = '0;
                    if (candValue != 2'd0) begin
                        valid_d  = 1'b1;
                        pontos_d = candValue;
                        sub_d    = sinalSync_q;
                        state_d  = ISSUE;
                    end else begin
                        rej_d   = 1'b1;
                        state_d = RELEASE;
                    end
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            ISSUE: begin
                count_d = '0;
                if (ready) begin
                    valid_d  = 1'b0;
                    pontos_d = '0;
                    sub_d    = 1'b0;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                if (press != 3'b000) begin
                    count_d = '0;
                end else if (count_q == CountLast) begin
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign valid     = valid_q;
    assign pontos    = pontos_q;
    assign sub       = sub_q;
    assign rejeitado = rej_q;

endmodule

// File: tb/tb_evento_pontos.sv
// Bench for evento_pontos with a short debounce window. A behavioural model
// built from run lengths of the synchronized press vector predicts every
// output each cycle; directed scenarios add event counts and latency checks.
module tb_evento_pontos;

    localparam int Deb = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] btn;
    logic       sinal;
    logic       ready;
    logic       valid;
    logic [1:0] pontos;
    logic       sub;
    logic       rejeitado;

    int testsRun  = 0;
    int failCount = 0;
    int cycleNo   = 0;

    // Model state: synchronizer delay line, run lengths and delivery phase.
    logic [2:0] mS1, mS2;
    logic       mSs1, mSs2;
    logic [2:0] mPrevPress;
    int         mRunLen;
    int         mZeroRun;
    bit         mArmed, mOffering, mReleasing;
    logic       mValid, mSub, mRej;
    logic [1:0] mPontos;

    // Per-scenario tallies.
    int         validCycles, rejCycles, events, firstValid;
    logic [1:0] lastPontos;
    logic       lastSub;

    logic [2:0] rndBtn;
    logic       rndSinal;
    int         rndHold;
    int         startCycle;

    evento_pontos #(.DEB_CYCLES(Deb)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .sinal     (sinal),
        .ready     (ready),
        .valid     (valid),
        .pontos    (pontos),
        .sub       (sub),
        .rejeitado (rejeitado)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch with tag and both values.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advances the model across one rising edge using the inputs present at that edge.
    task automatic modelStep();
        logic [2:0] p;
        logic       s;
        if (!reset) begin
            mS1 = 3'b111; mS2 = 3'b111; mSs1 = 1'b1; mSs2 = 1'b1;
            mPrevPress = 3'b000; mRunLen = 0; mZeroRun = 0;
            mArmed = 1'b1; mOffering = 1'b0; mReleasing = 1'b0;
            mValid = 1'b0; mPontos = 2'd0; mSub = 1'b0; mRej = 1'b0;
            return;
        end
        p = ~mS2;
        s = mSs2;
        if (p == mPrevPress) mRunLen++;
        else mRunLen = 1;
        mPrevPress = p;
        mRej = 1'b0;
        if (mArmed) begin
            // A press is accepted once the same nonzero vector was seen Deb+1 times in a row.
            if (p != 3'b000 && mRunLen >= Deb + 1) begin
                mArmed = 1'b0;
                if ($countones(p) == 1) begin
                    mOffering = 1'b1;
                    mValid    = 1'b1;
                    mPontos   = 2'($clog2(p) + 1);
                    mSub      = s;
                end else begin
                    mRej       = 1'b1;
                    mReleasing = 1'b1;
                    mZeroRun   = 0;
                end
            end
        end else if (mOffering) begin
            if (ready) begin
                mOffering = 1'b0; mValid = 1'b0; mPontos = 2'd0; mSub = 1'b0;
                mReleasing = 1'b1; mZeroRun = 0;
            end
        end else if (mReleasing) begin
            if (p == 3'b000) begin
                mZeroRun++;
                if (mZeroRun == Deb) begin
                    mReleasing = 1'b0;
                    mArmed     = 1'b1;
                end
            end else begin
                mZeroRun = 0;
            end
        end
        mS2 = mS1; mS1 = btn; mSs2 = mSs1; mSs1 = sinal;
    endtask

    task automatic clearTally();
        validCycles = 0; rejCycles = 0; events = 0; firstValid = -1;
        lastPontos = 2'd0; lastSub = 1'b0;
    endtask

    // Drives one cycle of inputs, steps the model, and checks all outputs after the edge.
    task automatic applyStimulus(input logic [2:0] b, input logic s, input logic r, input logic rstn);
        btn = b; sinal = s; ready = r; reset = rstn;
        if (valid === 1'b1 && r && rstn) events++;
        modelStep();
        @(posedge clk);
        #1;
        cycleNo++;
        checkOutput($sformatf("valid@%0d", cycleNo), {31'd0, valid}, {31'd0, mValid});
        checkOutput($sformatf("pontos@%0d", cycleNo), {30'd0, pontos}, {30'd0, mPontos});
        checkOutput($sformatf("sub@%0d", cycleNo), {31'd0, sub}, {31'd0, mSub});
        checkOutput($sformatf("rejeitado@%0d", cycleNo), {31'd0, rejeitado}, {31'd0, mRej});
        if (valid === 1'b1) begin
            validCycles++;
            if (firstValid < 0) firstValid = cycleNo;
            lastPontos = pontos;
            lastSub    = sub;
        end
        if (rejeitado === 1'b1) rejCycles++;
    endtask

    task automatic releaseAll(input int n);
        repeat (n) applyStimulus(3'b111, 1'b0, 1'b1, 1'b1);
    endtask

    // Directed scenarios followed by a randomized soak, all in one linear sequence.
    initial begin
        btn = 3'b111; sinal = 1'b0; ready = 1'b0; reset = 1'b0;
        clearTally();

        // Reset holds every output low.
        repeat (3) applyStimulus(3'b111, 1'b0, 1'b1, 1'b0);
        checkOutput("resetValid", {31'd0, valid}, 32'd0);
        checkOutput("resetRej", {31'd0, rejeitado}, 32'd0);
        releaseAll(2);

        // Clean +2 press held for 20 cycles.
        clearTally();
        startCycle = cycleNo;
        repeat (20) applyStimulus(3'b101, 1'b0, 1'b1, 1'b1);
        checkOutput("cleanEvents", validCycles, 32'd1);
        checkOutput("cleanLatency", firstValid - startCycle, Deb + 3);
        checkOutput("cleanPontos", {30'd0, lastPontos}, 32'd2);
        checkOutput("cleanSub", {31'd0, lastSub}, 32'd0);
        releaseAll(10);

        // +3 subtract press under backpressure.
        clearTally();
        for (int i = 0; i < 20 && valid !== 1'b1; i++) applyStimulus(3'b011, 1'b1, 1'b0, 1'b1);
        checkOutput("bpRise", {31'd0, valid}, 32'd1);
        clearTally();
        repeat (10) applyStimulus(3'b011, 1'b1, 1'b0, 1'b1);
        checkOutput("bpHeld", validCycles, 32'd10);
        checkOutput("bpPontos", {30'd0, lastPontos}, 32'd3);
        checkOutput("bpSub", {31'd0, lastSub}, 32'd1);
        applyStimulus(3'b011, 1'b1, 1'b1, 1'b1);
        checkOutput("bpCleared", {31'd0, valid}, 32'd0);
        checkOutput("bpEvents", events, 32'd1);
        releaseAll(10);

        // Bouncing btn[0] produces nothing until it settles.
        clearTally();
        for (int i = 0; i < 12; i++) applyStimulus(((i / 2) % 2) ? 3'b111 : 3'b110, 1'b0, 1'b1, 1'b1);
        checkOutput("bounceQuiet", validCycles, 32'd0);
        clearTally();
        repeat (15) applyStimulus(3'b110, 1'b0, 1'b1, 1'b1);
        checkOutput("bounceEvents", events, 32'd1);
        checkOutput("bouncePontos", {30'd0, lastPontos}, 32'd1);
        releaseAll(10);

        // Two buttons together are rejected.
        clearTally();
        repeat (12) applyStimulus(3'b100, 1'b0, 1'b1, 1'b1);
        checkOutput("doubleRej", rejCycles, 32'd1);
        checkOutput("doubleValid", validCycles, 32'd0);
        releaseAll(10);

        // Reset while an event is pending discards it; the held button is re-debounced.
        clearTally();
        for (int i = 0; i < 20 && valid !== 1'b1; i++) applyStimulus(3'b110, 1'b0, 1'b0, 1'b1);
        checkOutput("abortRise", {31'd0, valid}, 32'd1);
        applyStimulus(3'b110, 1'b0, 1'b0, 1'b0);
        checkOutput("abortCleared", {31'd0, valid}, 32'd0);
        clearTally();
        startCycle = cycleNo;
        repeat (20) applyStimulus(3'b110, 1'b0, 1'b1, 1'b1);
        checkOutput("abortFresh", events, 32'd1);
        checkOutput("abortLatency", firstValid - startCycle, Deb + 3);
        releaseAll(10);

        // A one-cycle glitch during release must not create an event.
        repeat (10) applyStimulus(3'b101, 1'b0, 1'b1, 1'b1);
        clearTally();
        releaseAll(2);
        applyStimulus(3'b101, 1'b0, 1'b1, 1'b1);
        releaseAll(12);
        checkOutput("glitchQuiet", validCycles, 32'd0);
        checkOutput("glitchRej", rejCycles, 32'd0);

        // Randomized soak: held vectors of random length, random ready, rare resets.
        for (int n = 0; n < 80; n++) begin
            rndBtn   = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom);
            rndSinal = 1'($urandom);
            rndHold  = $urandom_range(1, 12);
            for (int k = 0; k < rndHold; k++)
                applyStimulus(rndBtn, rndSinal, 1'($urandom_range(0, 1)), $urandom_range(0, 80) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
